// File: rtl/monitor_pkg.sv
// Shared definitions for the AXI-stream frame monitor: display source
// encodings and the display word-select width helper.
package monitor_pkg;

    typedef enum logic [2:0] {
        DISP_CAPTURE   = 3'd0,
        DISP_SNAPSHOT  = 3'd1,
        DISP_FRAME_CNT = 3'd2,
        DISP_BYTE_CNT  = 3'd3,
        DISP_ERR_CNT   = 3'd4,
        DISP_LAST_LEN  = 3'd5
    } disp_sel_e;

    // A single-word capture still gets a 1-bit selector.
    function automatic int word_sel_width(input int capture_bytes);
        return (capture_bytes / 4 > 1) ? $clog2(capture_bytes / 4) : 1;
    endfunction

endpackage

// File: rtl/axis_skid_buf.sv
// Two-entry AXI-stream skid buffer: registered tready, one cycle from
// accept to m_tvalid, full throughput with back-pressure absorbed by a skid slot.
module axis_skid_buf #(
    parameter int DATA_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [DATA_WIDTH-1:0] s_tdata,
    input  logic                  s_tvalid,
    output logic                  s_tready,
    input  logic                  s_tlast,
    input  logic                  s_tuser,
    output logic [DATA_WIDTH-1:0] m_tdata,
    output logic                  m_tvalid,
    input  logic                  m_tready,
    output logic                  m_tlast,
    output logic                  m_tuser
);

    localparam int PW = DATA_WIDTH + 2;

    logic [PW-1:0] out_q;
    logic [PW-1:0] skid_q;
    logic          out_valid;
    logic          skid_valid;
    logic          ready_q;
    logic          accept;
    logic          out_free;

    assign accept   = s_tvalid && ready_q;
    assign out_free = !out_valid || m_tready;

    // ready_q always equals "skid slot empty next cycle", so an accept never
    // coincides with a full skid slot.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_q      <= '0;
            skid_q     <= '0;
            out_valid  <= 1'b0;
            skid_valid <= 1'b0;
            ready_q    <= 1'b0;
        end else if (out_free) begin
            if (skid_valid) begin
                out_q      <= skid_q;
                out_valid  <= 1'b1;
                skid_valid <= 1'b0;
            end else if (accept) begin
                out_q     <= {s_tlast, s_tuser, s_tdata};
                out_valid <= 1'b1;
            end else begin
                out_valid <= 1'b0;
            end
            ready_q <= 1'b1;
        end else begin
            if (accept) begin
                skid_q     <= {s_tlast, s_tuser, s_tdata};
                skid_valid <= 1'b1;
            end
            ready_q <= !(skid_valid || accept);
        end
    end

    assign s_tready = ready_q;
    assign m_tvalid = out_valid;
    assign m_tlast  = out_q[PW-1];
    assign m_tuser  = out_q[PW-2];
    assign m_tdata  = out_q[DATA_WIDTH-1:0];

endmodule

// File: rtl/axis_frame_monitor.sv
// Pass-through AXI-stream monitor: keeps a trailing-byte capture, a snapshot
// of the last good frame's tail, and frame/byte/error/length statistics.
module axis_frame_monitor
    import monitor_pkg::*;
#(
    parameter int DATA_WIDTH    = 8,
    parameter int CAPTURE_BYTES = 4,
    parameter int COUNT_WIDTH   = 32
) (
    input  logic                                   clk,
    input  logic                                   rst_n,
    input  logic [DATA_WIDTH-1:0]                  s_axis_tdata,
    input  logic                                   s_axis_tvalid,
    output logic                                   s_axis_tready,
    input  logic                                   s_axis_tlast,
    input  logic                                   s_axis_tuser,
    output logic [DATA_WIDTH-1:0]                  m_axis_tdata,
    output logic                                   m_axis_tvalid,
    input  logic                                   m_axis_tready,
    output logic                                   m_axis_tlast,
    output logic                                   m_axis_tuser,
    input  logic                                   clr,
    input  logic [2:0]                             disp_sel,
    input  logic [word_sel_width(CAPTURE_BYTES)-1:0] disp_word,
    output logic [31:0]                            disp_data
);

    localparam int BPB    = DATA_WIDTH / 8;
    localparam int CAP_W  = CAPTURE_BYTES * 8;
    localparam int NWORDS = CAPTURE_BYTES / 4;
    localparam int WSW    = word_sel_width(CAPTURE_BYTES);
    localparam logic [COUNT_WIDTH-1:0] BPB_C = COUNT_WIDTH'(BPB);

    logic                   accept;
    logic [DATA_WIDTH-1:0]  beat_rev;
    logic [CAP_W-1:0]       capture;
    logic [CAP_W-1:0]       capture_shift;
    logic [CAP_W-1:0]       snapshot;
    logic [COUNT_WIDTH-1:0] frame_cnt;
    logic [COUNT_WIDTH-1:0] byte_cnt;
    logic [COUNT_WIDTH-1:0] err_cnt;
    logic [COUNT_WIDTH-1:0] last_len;
    logic [COUNT_WIDTH-1:0] run_len;
    logic [31:0]            cap_words  [2**WSW];
    logic [31:0]            snap_words [2**WSW];

    axis_skid_buf #(.DATA_WIDTH(DATA_WIDTH)) u_skid (
        .clk      (clk),
        .rst_n    (rst_n),
        .s_tdata  (s_axis_tdata),
        .s_tvalid (s_axis_tvalid),
        .s_tready (s_axis_tready),
        .s_tlast  (s_axis_tlast),
        .s_tuser  (s_axis_tuser),
        .m_tdata  (m_axis_tdata),
        .m_tvalid (m_axis_tvalid),
        .m_tready (m_axis_tready),
        .m_tlast  (m_axis_tlast),
        .m_tuser  (m_axis_tuser)
    );

    assign accept = s_axis_tvalid && s_axis_tready;

    // Lane 0 is the oldest byte, so it must end up highest in the capture.
    always_comb begin
        beat_rev = '0;
        for (int i = 0; i < BPB; i++) begin
            beat_rev[(BPB-1-i)*8 +: 8] = s_axis_tdata[i*8 +: 8];
        end
    end

    if (CAP_W > DATA_WIDTH) begin : g_shift
        assign capture_shift = {capture[CAP_W-DATA_WIDTH-1:0], beat_rev};
    end else begin : g_load
        assign capture_shift = beat_rev;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            capture   <= '0;
            snapshot  <= '0;
            frame_cnt <= '0;
            byte_cnt  <= '0;
            err_cnt   <= '0;
            last_len  <= '0;
            run_len   <= '0;
        end else if (clr) begin
            capture   <= '0;
            snapshot  <= '0;
            frame_cnt <= '0;
            byte_cnt  <= '0;
            err_cnt   <= '0;
            last_len  <= '0;
            run_len   <= '0;
        end else if (accept) begin
            capture  <= capture_shift;
            byte_cnt <= byte_cnt + BPB_C;
            if (s_axis_tlast) begin
                run_len <= '0;
                if (s_axis_tuser) begin
                    err_cnt <= err_cnt + 1'b1;
                end else begin
                    snapshot  <= capture_shift;
                    frame_cnt <= frame_cnt + 1'b1;
                    last_len  <= run_len + BPB_C;
                end
            end else begin
                run_len <= run_len + BPB_C;
            end
        end
    end

    // Selector codes past the last real word alias word 0.
    for (genvar w = 0; w < 2**WSW; w++) begin : g_words
        if (w < NWORDS) begin : g_real
            assign cap_words[w]  = capture[w*32 +: 32];
            assign snap_words[w] = snapshot[w*32 +: 32];
        end else begin : g_alias
            assign cap_words[w]  = capture[31:0];
            assign snap_words[w] = snapshot[31:0];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            disp_data <= '0;
        end else begin
            case (disp_sel)
                DISP_CAPTURE:   disp_data <= cap_words[disp_word];
                DISP_SNAPSHOT:  disp_data <= snap_words[disp_word];
                DISP_FRAME_CNT: disp_data <= 32'(frame_cnt);
                DISP_BYTE_CNT:  disp_data <= 32'(byte_cnt);
                DISP_ERR_CNT:   disp_data <= 32'(err_cnt);
                DISP_LAST_LEN:  disp_data <= 32'(last_len);
                default:        disp_data <= 32'h0;
            endcase
        end
    end

endmodule
